// File: rtl/reset_domain_responder.sv
// rtl/reset_domain_responder.sv - per-domain reset/init/clock-enable handshake responder
// Optional ack-state watchdog with fault_out: define RESET_RESPONDER_WATCHDOG_EN.
module reset_domain_responder #(
   parameter int RESETCYCLELENGTH = 16,
   parameter int INITCYCLELENGTH  = 8,
   parameter int SYNCSTAGES       = 2,
   parameter int TIMEOUTCYCLES    = 4096
) (
   input  logic       clk,
   input  logic       async_rst_n,
   input  logic       rst_req,
   input  logic       init_req,
   input  logic       clk_en_req,
   input  logic       local_rst_trigger,
   output logic       rst_ack,
   output logic       init_ack,
   output logic       rst_trigger_out,
   output logic       sync_rst_out,
   output logic       init_out,
   output logic       clk_en_out,
`ifdef RESET_RESPONDER_WATCHDOG_EN
   output logic       fault_out,
`endif
   output logic [2:0] state_out
);

   typedef enum logic [2:0] {
      S_HALT     = 3'd0,
      S_RESET    = 3'd1,
      S_RST_ACK  = 3'd2,
      S_READY    = 3'd3,
      S_INIT     = 3'd4,
      S_INIT_ACK = 3'd5,
      S_RUN      = 3'd6
   } state_t;

   localparam int MAXLEN = (RESETCYCLELENGTH > INITCYCLELENGTH) ? RESETCYCLELENGTH : INITCYCLELENGTH;
   localparam int CW = $clog2(MAXLEN + 1);
   localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
   localparam logic [CW-1:0] RST_LAST  = CW'(RESETCYCLELENGTH - 1);
   localparam logic [CW-1:0] INIT_LAST = CW'(INITCYCLELENGTH - 1);

   generate
      if (RESETCYCLELENGTH < 1 || INITCYCLELENGTH < 1 || SYNCSTAGES < 2 || TIMEOUTCYCLES < 1) begin : g_param_check
         $error("reset_domain_responder: parameter out of range");
      end
   endgenerate

   logic [SYNCSTAGES-1:0] rst_sync, init_sync, clk_en_sync;
   logic                  rst_s, init_s, clk_en_s;

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         rst_sync    <= '0;
         init_sync   <= '0;
         clk_en_sync <= '0;
      end else begin
         rst_sync    <= {rst_sync[SYNCSTAGES-2:0], rst_req};
         init_sync   <= {init_sync[SYNCSTAGES-2:0], init_req};
         clk_en_sync <= {clk_en_sync[SYNCSTAGES-2:0], clk_en_req};
      end
   end

   assign rst_s    = rst_sync[SYNCSTAGES-1];
   assign init_s   = init_sync[SYNCSTAGES-1];
   assign clk_en_s = clk_en_sync[SYNCSTAGES-1];

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            enter_reset;
   logic            trig_ok;
   logic            wd_timeout;
   logic            halt_go;
   logic            sync_rst_nxt, init_nxt, clk_en_nxt, rst_ack_nxt, init_ack_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         S_HALT:     if (halt_go) state_nxt = S_RESET;
         S_RESET:    if (cnt == RST_LAST) state_nxt = S_RST_ACK;
         S_RST_ACK: begin
            if (!rst_s)          state_nxt = S_READY;
            else if (wd_timeout) state_nxt = S_HALT;
         end
         S_READY: begin
            if (rst_s)       state_nxt = S_RESET;
            else if (init_s) state_nxt = S_INIT;
         end
         S_INIT: begin
            if (rst_s)                  state_nxt = S_RESET;
            else if (cnt == INIT_LAST)  state_nxt = S_INIT_ACK;
         end
         S_INIT_ACK: begin
            if (rst_s)           state_nxt = S_RESET;
            else if (!init_s)    state_nxt = S_RUN;
            else if (wd_timeout) state_nxt = S_HALT;
         end
         S_RUN:      if (rst_s) state_nxt = S_RESET;
         default:    state_nxt = S_HALT;
      endcase

      // Counter restarts on every state change so each pass measures its own length
      if (state_nxt != state)  cnt_nxt = '0;
      else if (cnt != CNT_MAX) cnt_nxt = cnt + CW'(1);
      else                     cnt_nxt = cnt;

      enter_reset  = (state_nxt == S_RESET) && (state != S_RESET);
      trig_ok      = (state == S_READY) || (state == S_INIT) || (state == S_INIT_ACK) || (state == S_RUN);
      sync_rst_nxt = (state_nxt == S_HALT) || (state_nxt == S_RESET);
      init_nxt     = (state_nxt == S_INIT);
      rst_ack_nxt  = (state_nxt == S_RST_ACK);
      init_ack_nxt = (state_nxt == S_INIT_ACK);
      clk_en_nxt   = (state_nxt == S_RUN) && clk_en_s;
   end

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         state           <= S_HALT;
         cnt             <= '0;
         sync_rst_out    <= 1'b1;
         init_out        <= 1'b0;
         clk_en_out      <= 1'b0;
         rst_ack         <= 1'b0;
         init_ack        <= 1'b0;
         rst_trigger_out <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         sync_rst_out <= sync_rst_nxt;
         init_out     <= init_nxt;
         clk_en_out   <= clk_en_nxt;
         rst_ack      <= rst_ack_nxt;
         init_ack     <= init_ack_nxt;
         if (enter_reset)
            rst_trigger_out <= 1'b0;
         else if (local_rst_trigger && trig_ok)
            rst_trigger_out <= 1'b1;
      end
   end

   assign state_out = state;

`ifdef RESET_RESPONDER_WATCHDOG_EN
   localparam int WW = $clog2(TIMEOUTCYCLES + 1);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUTCYCLES - 1);

   logic [WW-1:0] wd_cnt;
   logic          wd_req;
   logic          rst_s_q;

   assign wd_req     = ((state == S_RST_ACK) && rst_s) || ((state == S_INIT_ACK) && init_s);
   assign wd_timeout = wd_req && (wd_cnt == WD_LAST);
   // After a fault a still-held request must drop and rise again, or HALT would re-enter RESET at once
   assign halt_go    = rst_s && (!fault_out || !rst_s_q);

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         wd_cnt    <= '0;
         rst_s_q   <= 1'b0;
         fault_out <= 1'b0;
      end else begin
         rst_s_q <= rst_s;
         if (!wd_req)
            wd_cnt <= '0;
         else if (!wd_timeout)
            wd_cnt <= wd_cnt + WW'(1);
         if (enter_reset)
            fault_out <= 1'b0;
         else if (wd_timeout)
            fault_out <= 1'b1;
      end
   end
`else
   assign wd_timeout = 1'b0;
   assign halt_go    = rst_s;
`endif

endmodule
